// File: rtl/knn_load_pkg.sv
// Shared definitions for the KNN load sequencer: FSM state encoding and the
// width helper used to size the word-index and channel fields.
package knn_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    // clog2 with a floor of 1 so single-word / single-channel builds keep a real bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/knn_sat_cnt.sv
// Saturating record counter with synchronous reset, soft clear and increment.
module knn_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/knn_load_seq.sv
// Write sequencer for the KNN register interface: groups NWORDS accepted CPU
// writes into a channel-tagged record and signals record completion.
module knn_load_seq
    import knn_load_pkg::*;
#(
    parameter int NWORDS    = 2,
    parameter int NCHAN     = 2,
    parameter int CNT_W     = 8,
    parameter int HANDSHAKE = 0,
    parameter int IDX_W     = knn_load_pkg::width_of(NWORDS),
    parameter int CH_W      = knn_load_pkg::width_of(NCHAN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clear,
    input  logic                   valid,
    input  logic                   wstrb,
    input  logic [CH_W-1:0]        chan,
    input  logic                   ack,
    output logic                   word_we,
    output logic [IDX_W-1:0]       word_idx,
    output logic                   data_loaded,
    output logic [CH_W-1:0]        loaded_chan,
    output logic [NCHAN*CNT_W-1:0] rec_cnt,
    output logic                   err,
    output logic                   busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam bit               HS       = (HANDSHAKE != 0);

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [CH_W-1:0]  lch_q;
    logic             err_q;

    logic wr;
    logic start;
    logic fill;

    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        wr      = valid & wstrb & en;
        start   = 1'b0;
        fill    = 1'b0;
        if (wr) begin
            start = (state == IDLE) || ((state == DONE) && !HS);
            fill  = (state == FILL) && (chan == lch_q);
        end
        word_we = start | fill;
    end

    // Any write the FSM cannot take (channel switch mid-record, or a write
    // while a completed record is still owned by the datapath) is dropped.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= IDLE;
            idx_q <= '0;
            lch_q <= '0;
            err_q <= 1'b0;
        end else if (en) begin
            if (wr && !word_we) begin
                err_q <= 1'b1;
            end
            if (start) begin
                lch_q <= chan;
                if (NWORDS == 1) begin
                    state <= DONE;
                end else begin
                    state <= FILL;
                    idx_q <= IDX_W'(1);
                end
            end else begin
                unique case (state)
                    FILL: begin
                        if (fill) begin
                            if (idx_q == LAST_IDX) begin
                                state <= DONE;
                                idx_q <= '0;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                    DONE: state <= HS ? HOLD : IDLE;
                    HOLD: if (ack) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    // DONE lasts exactly one enabled cycle, so each record bumps its counter once.
    for (genvar k = 0; k < NCHAN; k++) begin : g_cnt
        knn_sat_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clear(clear),
            .inc  (en && (state == DONE) && (lch_q == CH_W'(k))),
            .cnt  (rec_cnt[k*CNT_W +: CNT_W])
        );
    end

    assign word_idx    = idx_q;
    assign loaded_chan = lch_q;
    assign err         = err_q;
    assign data_loaded = (state == DONE) || (state == HOLD);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_knn_load_seq.sv
// Scoreboard bench for knn_load_seq: three builds (default, handshake,
// single-word saturating) driven by directed per-cycle vectors.
module tb_knn_load_seq;

    typedef struct packed {
        logic rst;
        logic clear;
        logic en;
        logic valid;
        logic wstrb;
        logic chan;
        logic ack;
    } in_t;

    typedef struct {
        int          dut;
        string       name;
        logic [31:0] exp;
    } sb_t;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    in_t in_a = '0, in_b = '0, in_c = '0;

    logic        a_we, a_idx, a_dl, a_lch, a_err, a_busy;
    logic [15:0] a_cnt;
    logic        b_we, b_idx, b_dl, b_lch, b_err, b_busy;
    logic [15:0] b_cnt;
    logic        c_we, c_idx, c_dl, c_lch, c_err, c_busy;
    logic [1:0]  c_cnt;

    knn_load_seq u_a (
        .clk(clk), .rst(in_a.rst), .en(in_a.en), .clear(in_a.clear),
        .valid(in_a.valid), .wstrb(in_a.wstrb), .chan(in_a.chan), .ack(in_a.ack),
        .word_we(a_we), .word_idx(a_idx), .data_loaded(a_dl), .loaded_chan(a_lch),
        .rec_cnt(a_cnt), .err(a_err), .busy(a_busy)
    );

    knn_load_seq #(.HANDSHAKE(1)) u_b (
        .clk(clk), .rst(in_b.rst), .en(in_b.en), .clear(in_b.clear),
        .valid(in_b.valid), .wstrb(in_b.wstrb), .chan(in_b.chan), .ack(in_b.ack),
        .word_we(b_we), .word_idx(b_idx), .data_loaded(b_dl), .loaded_chan(b_lch),
        .rec_cnt(b_cnt), .err(b_err), .busy(b_busy)
    );

    knn_load_seq #(.NWORDS(1), .NCHAN(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(in_c.rst), .en(in_c.en), .clear(in_c.clear),
        .valid(in_c.valid), .wstrb(in_c.wstrb), .chan(in_c.chan), .ack(in_c.ack),
        .word_we(c_we), .word_idx(c_idx), .data_loaded(c_dl), .loaded_chan(c_lch),
        .rec_cnt(c_cnt), .err(c_err), .busy(c_busy)
    );

    sb_t         sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          row_n = 0;
    sb_t         mon_e;
    logic [31:0] mon_act;

    function automatic logic [31:0] pack(input logic we, idx, dl, lch, e, bsy,
                                         input logic [15:0] cnt);
        return {10'd0, we, idx, dl, lch, e, bsy, cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {we,idx,dl,lch,err,busy,cnt}=%h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; if chk, queue the outputs expected during this cycle.
    task automatic row(input int dut, input string grp, input bit chk,
                       input bit r, c, e, v, w, ch, a, input logic [31:0] exp);
        in_t x;
        sb_t s;
        x = {r, c, e, v, w, ch, a};
        case (dut)
            0:       in_a = x;
            1:       in_b = x;
            default: in_c = x;
        endcase
        row_n++;
        if (chk) begin
            s.dut  = dut;
            s.name = $sformatf("%s_row%0d", grp, row_n);
            s.exp  = exp;
            sb_q.push_back(s);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.dut)
                0:       mon_act = pack(a_we, a_idx, a_dl, a_lch, a_err, a_busy, a_cnt);
                1:       mon_act = pack(b_we, b_idx, b_dl, b_lch, b_err, b_busy, b_cnt);
                default: mon_act = pack(c_we, c_idx, c_dl, c_lch, c_err, c_busy, {14'd0, c_cnt});
            endcase
            check(mon_e.name, mon_act, mon_e.exp);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // Default build: basic record, back-to-back records, channel switch error
        row(0, "a_rst",   0, 1,0,1,0,0,0,0, 0);
        row(0, "a_rst",   1, 1,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0000));
        row(0, "a_rec",   1, 0,0,1,1,1,0,0, pack(1,0,0,0,0,0,16'h0000));
        row(0, "a_rec",   1, 0,0,1,1,1,0,0, pack(1,1,0,0,0,1,16'h0000));
        row(0, "a_rec",   1, 0,0,1,0,0,0,0, pack(0,0,1,0,0,1,16'h0000));
        row(0, "a_rec",   1, 0,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0001));
        row(0, "a_b2b",   1, 0,0,1,1,1,1,0, pack(1,0,0,0,0,0,16'h0001));
        row(0, "a_b2b",   1, 0,0,1,1,1,1,0, pack(1,1,0,1,0,1,16'h0001));
        row(0, "a_b2b",   1, 0,0,1,1,1,1,0, pack(1,0,1,1,0,1,16'h0001));
        row(0, "a_b2b",   1, 0,0,1,1,1,1,0, pack(1,1,0,1,0,1,16'h0101));
        row(0, "a_b2b",   1, 0,0,1,0,0,0,0, pack(0,0,1,1,0,1,16'h0101));
        row(0, "a_b2b",   1, 0,0,1,0,0,0,0, pack(0,0,0,1,0,0,16'h0201));
        row(0, "a_chsw",  1, 0,0,1,1,1,0,0, pack(1,0,0,1,0,0,16'h0201));
        row(0, "a_chsw",  1, 0,0,1,1,1,1,0, pack(0,1,0,0,0,1,16'h0201));
        row(0, "a_chsw",  1, 0,0,1,1,1,0,0, pack(1,1,0,0,1,1,16'h0201));
        row(0, "a_chsw",  1, 0,0,1,0,0,0,0, pack(0,0,1,0,1,1,16'h0201));
        row(0, "a_chsw",  1, 0,0,1,0,0,0,0, pack(0,0,0,0,1,0,16'h0202));
        row(0, "a_clr",   1, 0,1,1,0,0,0,0, pack(0,0,0,0,1,0,16'h0202));
        row(0, "a_clr",   1, 0,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0000));
        // Enable freeze mid-record, then abandon with clear and with rst
        row(0, "a_frz",   1, 0,0,1,1,1,1,0, pack(1,0,0,0,0,0,16'h0000));
        row(0, "a_frz",   1, 0,0,0,1,1,1,0, pack(0,1,0,1,0,1,16'h0000));
        row(0, "a_frz",   1, 0,0,0,1,1,1,0, pack(0,1,0,1,0,1,16'h0000));
        row(0, "a_frz",   1, 0,0,0,1,1,1,0, pack(0,1,0,1,0,1,16'h0000));
        row(0, "a_frz",   1, 0,1,1,0,0,0,0, pack(0,1,0,1,0,1,16'h0000));
        row(0, "a_frz",   1, 0,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0000));
        row(0, "a_abrst", 1, 0,0,1,1,1,0,0, pack(1,0,0,0,0,0,16'h0000));
        row(0, "a_abrst", 1, 1,0,1,0,0,0,0, pack(0,1,0,0,0,1,16'h0000));
        row(0, "a_abrst", 1, 0,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0000));
        // Enable low while DONE: completion held, single increment on resume
        row(0, "a_dfrz",  1, 0,0,1,1,1,0,0, pack(1,0,0,0,0,0,16'h0000));
        row(0, "a_dfrz",  1, 0,0,1,1,1,0,0, pack(1,1,0,0,0,1,16'h0000));
        row(0, "a_dfrz",  1, 0,0,0,0,0,0,0, pack(0,0,1,0,0,1,16'h0000));
        row(0, "a_dfrz",  1, 0,0,0,0,0,0,0, pack(0,0,1,0,0,1,16'h0000));
        row(0, "a_dfrz",  1, 0,0,1,0,0,0,0, pack(0,0,1,0,0,1,16'h0000));
        row(0, "a_dfrz",  1, 0,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0001));
        row(0, "a_clren", 1, 0,1,0,0,0,0,0, pack(0,0,0,0,0,0,16'h0001));
        row(0, "a_clren", 1, 0,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0000));

        // Handshake build: held completion, dropped writes, ack beats write
        row(1, "b_rst",   0, 1,0,1,0,0,0,0, 0);
        row(1, "b_rst",   1, 1,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0000));
        row(1, "b_hs",    1, 0,0,1,1,1,0,0, pack(1,0,0,0,0,0,16'h0000));
        row(1, "b_hs",    1, 0,0,1,1,1,0,0, pack(1,1,0,0,0,1,16'h0000));
        row(1, "b_hs",    1, 0,0,1,1,1,0,0, pack(0,0,1,0,0,1,16'h0000));
        row(1, "b_hs",    1, 0,0,1,1,1,0,0, pack(0,0,1,0,1,1,16'h0001));
        row(1, "b_hs",    1, 0,0,1,1,1,0,0, pack(0,0,1,0,1,1,16'h0001));
        row(1, "b_ack",   1, 0,0,1,1,1,0,1, pack(0,0,1,0,1,1,16'h0001));
        row(1, "b_ack",   1, 0,0,1,0,0,0,1, pack(0,0,0,0,1,0,16'h0001));
        row(1, "b_ack",   1, 0,0,1,0,0,0,0, pack(0,0,0,0,1,0,16'h0001));

        // Single-word build with 2-bit counter: saturation at 3
        row(2, "c_rst",   0, 1,0,1,0,0,0,0, 0);
        row(2, "c_rst",   1, 1,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0000));
        row(2, "c_sat",   1, 0,0,1,1,1,0,0, pack(1,0,0,0,0,0,16'h0000));
        row(2, "c_sat",   1, 0,0,1,1,1,0,0, pack(1,0,1,0,0,1,16'h0000));
        row(2, "c_sat",   1, 0,0,1,1,1,0,0, pack(1,0,1,0,0,1,16'h0001));
        row(2, "c_sat",   1, 0,0,1,1,1,0,0, pack(1,0,1,0,0,1,16'h0002));
        row(2, "c_sat",   1, 0,0,1,1,1,0,0, pack(1,0,1,0,0,1,16'h0003));
        row(2, "c_sat",   1, 0,0,1,0,0,0,0, pack(0,0,1,0,0,1,16'h0003));
        row(2, "c_sat",   1, 0,0,1,0,0,0,0, pack(0,0,0,0,0,0,16'h0003));

        repeat (4) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
